// File: rtl/set_bit_enumerator.sv
`default_nettype none
// ============================================================================
//  Module   : set_bit_enumerator
//  Purpose  : Accepts an N-bit word and emits its set bits one per beat as a
//             one-hot mask plus binary index. The order is MSB-first or
//             LSB-first and is chosen per word. Valid/ready handshakes are
//             used on both the input and output sides.
//  Ports    : clk, rst_n (async, active-low)
//             in_valid/in_ready/in_data/in_dir : word input (dir 1 = LSB-first)
//             abort                            : drop the current word
//             out_valid/out_ready              : beat handshake
//             out_mask/out_idx/out_seq         : bit, position, beat ordinal
//             out_last/out_empty               : final beat / all-zero word
//  Revision : 1.0 - initial release
// ============================================================================
module set_bit_enumerator #(
  parameter  int N  = 32,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_dir,
  input  logic          abort,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_mask,
  output logic [IW-1:0] out_idx,
  output logic [IW-1:0] out_seq,
  output logic          out_last,
  output logic          out_empty
);

  localparam logic [N-1:0]  C_ONE_N  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0] C_ONE_IW = {{(IW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [N-1:0]  r_res;     // bits of the current word not yet emitted
  logic          r_dir;
  logic [IW-1:0] r_seq;
  logic          r_zero;

  logic [N-1:0]  w_smear;
  logic [N-1:0]  w_mask_msb;
  logic [N-1:0]  w_mask_lsb;
  logic [N-1:0]  w_mask;
  logic [IW-1:0] w_idx;
  logic          w_last;
  logic          w_accept;
  logic          w_load;

  // Beat selection from the residual word.
  always_comb begin
    // The smear fills every bit below the highest set bit, so the edge of the
    // smeared word isolates the MSB. IW stages also cover non-power-of-2 N.
    w_smear = r_res;
    for (int k = 0; k < IW; k++) begin
      w_smear = w_smear | (w_smear >> (1 << k));
    end
    w_mask_msb = w_smear & ~(w_smear >> 1);
    w_mask_lsb = r_res & (~r_res + C_ONE_N);
    w_mask     = r_dir ? w_mask_lsb : w_mask_msb;

    // The mask is one-hot (or zero), so OR-ing the indices acts as an encoder.
    w_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (w_mask[i]) begin
        w_idx = w_idx | IW'(i);
      end
    end

    // An all-zero word has an empty residual, so its single beat is last.
    w_last = ((r_res & ~w_mask) == '0);
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    out_valid   = (r_state == ST_EMIT);
    w_accept    = out_valid & out_ready;
    // The ready path is combinational through out_ready. This allows a new
    // word to load on the same edge that retires the previous last beat.
    in_ready    = ((r_state == ST_IDLE) | (w_accept & w_last)) & ~abort;
    w_load      = in_valid & in_ready;

    case (r_state)
      ST_IDLE: begin
        if (w_load) begin
          w_state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_accept & w_last) begin
          w_state_nxt = w_load ? ST_EMIT : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    out_mask  = out_valid ? w_mask : '0;
    out_idx   = out_valid ? w_idx : '0;
    out_seq   = out_valid ? r_seq : '0;
    out_last  = out_valid & w_last;
    out_empty = out_valid & r_zero;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res  <= '0;
      r_dir  <= 1'b0;
      r_seq  <= '0;
      r_zero <= 1'b0;
    end else if (abort) begin
      r_res  <= '0;
      r_seq  <= '0;
      r_zero <= 1'b0;
    end else if (w_load) begin
      r_res  <= in_data;
      r_dir  <= in_dir;
      r_seq  <= '0;
      r_zero <= (in_data == '0);
    end else if (w_accept) begin
      r_res  <= r_res & ~w_mask;
      r_seq  <= r_seq + C_ONE_IW;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_set_bit_enumerator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_set_bit_enumerator
//  Purpose  : Self-checking bench for set_bit_enumerator. An N=8 instance is
//             checked every cycle against a queue-based beat model, plus
//             literal expectations. An N=32 instance walks a full word.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_set_bit_enumerator;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // N = 8 instance
  logic       in_valid, in_ready, in_dir, abort, out_valid, out_ready;
  logic       out_last, out_empty;
  logic [7:0] in_data, out_mask;
  logic [2:0] out_idx, out_seq;

  // N = 32 instance
  logic        in_valid32, in_ready32, in_dir32, abort32, out_valid32, out_ready32;
  logic        out_last32, out_empty32;
  logic [31:0] in_data32, out_mask32;
  logic [4:0]  out_idx32, out_seq32;

  set_bit_enumerator #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_dir(in_dir),
    .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask),
    .out_idx(out_idx), .out_seq(out_seq), .out_last(out_last), .out_empty(out_empty)
  );

  set_bit_enumerator #(.N(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_data(in_data32), .in_dir(in_dir32),
    .abort(abort32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_mask(out_mask32),
    .out_idx(out_idx32), .out_seq(out_seq32), .out_last(out_last32), .out_empty(out_empty32)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // ---------------- behavioural model (N = 8) ----------------
  typedef struct packed {
    logic [7:0] mask;
    logic [2:0] idx;
    logic [2:0] seq;
    logic       last;
    logic       empty;
  } beat_t;

  beat_t q[$];

  // Lists the beats a word must produce, in emission order.
  function automatic void push_word(input logic [7:0] w, input logic d);
    beat_t b;
    int    n;
    int    total;
    int    pos;
    n     = 0;
    total = $countones(w);
    if (w == 8'h00) begin
      b.mask = 8'h00; b.idx = 3'd0; b.seq = 3'd0; b.last = 1'b1; b.empty = 1'b1;
      q.push_back(b);
    end else begin
      for (int k = 0; k < 8; k++) begin
        pos = d ? k : 7 - k;
        if (w[pos]) begin
          b.mask  = 8'h01 << pos;
          b.idx   = 3'(pos);
          b.seq   = 3'(n);
          b.last  = (n == total - 1);
          b.empty = 1'b0;
          q.push_back(b);
          n++;
        end
      end
    end
  endfunction

  logic       s_acc = 1'b0, s_load = 1'b0, s_abort = 1'b0, s_dir = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       ev, er;

  // Compare on the falling edge; inputs only change just after rising edges.
  always @(negedge clk) begin
    if (!rst_n) q.delete();
    ev = (q.size() != 0);
    er = !abort;
    if (ev) er = er && (!out_ready || q[0].last) ? (out_ready && q[0].last) && !abort : !abort && 1'b0;
    if (!ev) er = !abort;
    chk("model_out_valid", 32'(out_valid), 32'(ev));
    chk("model_in_ready", 32'(in_ready), 32'(er));
    if (ev) begin
      chk("model_mask",  32'(out_mask),  32'(q[0].mask));
      chk("model_idx",   32'(out_idx),   32'(q[0].idx));
      chk("model_seq",   32'(out_seq),   32'(q[0].seq));
      chk("model_last",  32'(out_last),  32'(q[0].last));
      chk("model_empty", 32'(out_empty), 32'(q[0].empty));
    end
    s_acc   = ev && out_ready && rst_n;
    s_load  = in_valid && er && rst_n;
    s_abort = abort && rst_n;
    s_data  = in_data;
    s_dir   = in_dir;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (s_acc) void'(q.pop_front());
      if (s_abort) q.delete();
      if (s_load) push_word(s_data, s_dir);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [7:0] w, input logic d);
    in_valid = 1'b1; in_data = w; in_dir = d;
    cyc();
    in_valid = 1'b0;
  endtask

  logic [7:0] lm[4];
  logic [2:0] li[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; in_dir = 1'b0; abort = 1'b0; out_ready = 1'b1;
    in_valid32 = 1'b0; in_data32 = 32'h0; in_dir32 = 1'b0; abort32 = 1'b0; out_ready32 = 1'b1;
    repeat (2) cyc();

    // Reset values
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_mask",      32'(out_mask),  32'd0);
    chk("rst_idx",       32'(out_idx),   32'd0);
    chk("rst_seq",       32'(out_seq),   32'd0);
    chk("rst_last",      32'(out_last),  32'd0);
    chk("rst_empty",     32'(out_empty), 32'd0);
    rst_n = 1'b1;
    cyc();

    // 0xA5, MSB-first: the first beat appears one cycle after the load
    lm = '{8'h80, 8'h20, 8'h04, 8'h01};
    li = '{3'd7, 3'd5, 3'd2, 3'd0};
    load8(8'hA5, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_mask",  32'(out_mask),  32'(lm[k]));
      chk("t1_idx",   32'(out_idx),   32'(li[k]));
      chk("t1_seq",   32'(out_seq),   32'(k));
      chk("t1_last",  32'(out_last),  32'(k == 3));
    end
    cyc();

    // 0xA5, LSB-first
    lm = '{8'h01, 8'h04, 8'h20, 8'h80};
    li = '{3'd0, 3'd2, 3'd5, 3'd7};
    load8(8'hA5, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_mask", 32'(out_mask), 32'(lm[k]));
      chk("t2_idx",  32'(out_idx),  32'(li[k]));
    end
    cyc();

    // Empty word: a single all-zero beat
    load8(8'h00, 1'b0);
    @(negedge clk);
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_mask",  32'(out_mask),  32'd0);
    chk("t3_idx",   32'(out_idx),   32'd0);
    chk("t3_last",  32'(out_last),  32'd1);
    chk("t3_empty", 32'(out_empty), 32'd1);
    @(negedge clk);
    chk("t3_after_valid", 32'(out_valid), 32'd0);
    chk("t3_after_ready", 32'(in_ready),  32'd1);
    cyc();

    // Backpressure on the second beat
    load8(8'hA5, 1'b0);
    cyc();
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t4_hold_mask", 32'(out_mask), 32'h20);
      chk("t4_hold_idx",  32'(out_idx),  32'd5);
      cyc();
    end
    out_ready = 1'b1;
    repeat (5) cyc();

    // Back-to-back words with in_valid held
    in_valid = 1'b1; in_data = 8'h81; in_dir = 1'b1;
    cyc();
    in_data = 8'h18;
    @(negedge clk);
    chk("t5_b0", 32'(out_mask), 32'h01);
    @(negedge clk);
    chk("t5_b1", 32'(out_mask), 32'h80);
    chk("t5_reload_ready", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_b2", 32'(out_mask), 32'h08);
    @(negedge clk);
    chk("t5_b3", 32'(out_mask), 32'h10);
    chk("t5_b3_last", 32'(out_last), 32'd1);
    repeat (2) cyc();

    // Abort after the second beat
    load8(8'hFF, 1'b0);
    @(negedge clk);
    chk("t6_b0", 32'(out_mask), 32'h80);
    cyc();
    @(negedge clk);
    chk("t6_b1", 32'(out_mask), 32'h40);
    cyc();
    abort = 1'b1;
    @(negedge clk);
    chk("t6_abort_ready", 32'(in_ready), 32'd0);
    cyc();
    abort = 1'b0;
    @(negedge clk);
    chk("t6_post_valid", 32'(out_valid), 32'd0);
    chk("t6_post_ready", 32'(in_ready),  32'd1);
    cyc();

    // Reset in the middle of a word clears outputs without a clock edge
    load8(8'hFF, 1'b1);
    repeat (2) cyc();
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    chk("t6_async_mask",  32'(out_mask),  32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // N = 32, all ones, MSB-first: 32 beats walking idx 31..0
    in_valid32 = 1'b1; in_data32 = 32'hFFFF_FFFF; in_dir32 = 1'b0;
    cyc();
    in_valid32 = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      chk("t7_valid", 32'(out_valid32), 32'd1);
      chk("t7_idx",   32'(out_idx32),   32'(31 - k));
      chk("t7_mask",  out_mask32,       32'h8000_0000 >> k);
      chk("t7_seq",   32'(out_seq32),   32'(k));
      chk("t7_last",  32'(out_last32),  32'(k == 31));
    end
    @(negedge clk);
    chk("t7_done_valid", 32'(out_valid32), 32'd0);
    chk("t7_done_ready", 32'(in_ready32),  32'd1);
    cyc();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
